sc_microsequencer: RTL and testbench

- Control unit that sequences the register-file/ALU datapath through fetch, PC-increment, decode and execute.
- Drives the datapath's load/clear decoder selections, bus A/B/C control codes and selectors, and ALU selection, and handshakes instruction fetch with memory.
- Sits beside the datapath in the CPU top level; consumes IR fields and ALU flags.

---
 rtl/sc_microsequencer_if.sv | 50 +++++
 rtl/sc_microsequencer.sv | 130 +++++++++++++
 tb/tb_sc_microsequencer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/sc_microsequencer_if.sv
// sc_microsequencer_if: control/handshake bundle between the microsequencer and the datapath/memory.
// Carries uCONTROL_step_InHigh only when SC_MICROSEQUENCER_SINGLE_STEP_EN is defined.
interface sc_microsequencer_if #(
  parameter int DATAWIDTH_BUS = 32,
  parameter int DATAWIDTH_DECODER_SELECTION = 4,
  parameter int DATAWIDTH_ALU_SELECTION = 4,
  parameter int DATA_BUS_CONTROL = 6
);
  logic uCONTROL_start_InHigh;
  logic [DATAWIDTH_BUS-1:0] uCONTROL_ir_InBUS;
  logic uCONTROL_zero_InLow;
  logic uCONTROL_memack_InHigh;
`ifdef SC_MICROSEQUENCER_SINGLE_STEP_EN
  logic uCONTROL_step_InHigh;
`endif
  logic uCONTROL_memreq_OutHigh;
  logic [DATAWIDTH_DECODER_SELECTION-1:0] uCONTROL_loadselection_OutBUS;
  logic [DATAWIDTH_DECODER_SELECTION-1:0] uCONTROL_clearselection_OutBUS;
  logic [DATAWIDTH_ALU_SELECTION-1:0] uCONTROL_aluselection_OutBUS;
  logic [DATA_BUS_CONTROL-1:0] uCONTROL_BUS_CONTROL_A;
  logic [DATA_BUS_CONTROL-1:0] uCONTROL_BUS_CONTROL_B;
  logic [DATA_BUS_CONTROL-1:0] uCONTROL_BUS_CONTROL_C;
  logic uCONTROL_BUS_SELECTOR_A;
  logic uCONTROL_BUS_SELECTOR_B;
  logic uCONTROL_BUS_SELECTOR_C;
  logic uCONTROL_busy_OutHigh;
  logic uCONTROL_halted_OutHigh;
  logic uCONTROL_illegal_OutHigh;
  logic [15:0] uCONTROL_retired_OutBUS;
  modport master (
`ifdef SC_MICROSEQUENCER_SINGLE_STEP_EN
    input uCONTROL_step_InHigh,
`endif
    input uCONTROL_start_InHigh, uCONTROL_ir_InBUS, uCONTROL_zero_InLow, uCONTROL_memack_InHigh,
    output uCONTROL_memreq_OutHigh, uCONTROL_loadselection_OutBUS, uCONTROL_clearselection_OutBUS,
    output uCONTROL_aluselection_OutBUS, uCONTROL_BUS_CONTROL_A, uCONTROL_BUS_CONTROL_B, uCONTROL_BUS_CONTROL_C,
    output uCONTROL_BUS_SELECTOR_A, uCONTROL_BUS_SELECTOR_B, uCONTROL_BUS_SELECTOR_C,
    output uCONTROL_busy_OutHigh, uCONTROL_halted_OutHigh, uCONTROL_illegal_OutHigh, uCONTROL_retired_OutBUS
  );
  modport slave (
`ifdef SC_MICROSEQUENCER_SINGLE_STEP_EN
    output uCONTROL_step_InHigh,
`endif
    output uCONTROL_start_InHigh, uCONTROL_ir_InBUS, uCONTROL_zero_InLow, uCONTROL_memack_InHigh,
    input uCONTROL_memreq_OutHigh, uCONTROL_loadselection_OutBUS, uCONTROL_clearselection_OutBUS,
    input uCONTROL_aluselection_OutBUS, uCONTROL_BUS_CONTROL_A, uCONTROL_BUS_CONTROL_B, uCONTROL_BUS_CONTROL_C,
    input uCONTROL_BUS_SELECTOR_A, uCONTROL_BUS_SELECTOR_B, uCONTROL_BUS_SELECTOR_C,
    input uCONTROL_busy_OutHigh, uCONTROL_halted_OutHigh, uCONTROL_illegal_OutHigh, uCONTROL_retired_OutBUS
  );
endinterface

// File: rtl/sc_microsequencer.sv
// sc_microsequencer: fetch / PC-increment / decode / execute control unit for the register-file/ALU datapath.
// Optional single-step PAUSE after every retire: SC_MICROSEQUENCER_SINGLE_STEP_EN.
module sc_microsequencer #(
  parameter int DATAWIDTH_BUS = 32,
  parameter int DATAWIDTH_DECODER_SELECTION = 4,
  parameter int DATAWIDTH_ALU_SELECTION = 4,
  parameter int DATA_BUS_CONTROL = 6,
  parameter logic [DATAWIDTH_DECODER_SELECTION-1:0] SEL_NONE = 4'b1111,
  parameter logic [DATAWIDTH_DECODER_SELECTION-1:0] REG_PC = 4'd5,
  parameter logic [DATAWIDTH_DECODER_SELECTION-1:0] REG_IR = 4'd6,
  parameter logic [DATAWIDTH_ALU_SELECTION-1:0] ALU_SEL_PASSA = 4'b0000,
  parameter logic [DATAWIDTH_ALU_SELECTION-1:0] ALU_SEL_INCA = 4'b0001
)(
  input logic uCONTROL_CLOCK_50,
  input logic uCONTROL_RESET_InHigh,
  sc_microsequencer_if.master bus
);
  typedef enum logic [2:0] {
    IDLE, FETCH, PCINC, DECODE, EXEC, BRANCH, HALT
`ifdef SC_MICROSEQUENCER_SINGLE_STEP_EN
    , PAUSE
`endif
  } state_t;
`ifdef SC_MICROSEQUENCER_SINGLE_STEP_EN
  localparam state_t S_RETIRE = PAUSE;
`else
  localparam state_t S_RETIRE = FETCH;
`endif
  localparam logic [DATA_BUS_CONTROL-1:0] CTL_PC = DATA_BUS_CONTROL'(REG_PC);
  state_t r_state, w_next;
  logic [DATAWIDTH_DECODER_SELECTION-1:0] r_load, r_clear, w_load, w_clear;
  logic [DATAWIDTH_ALU_SELECTION-1:0] r_alu, w_alu;
  logic [DATA_BUS_CONTROL-1:0] r_ca, r_cc, w_ca, w_cc;
  logic r_sa, r_sb, r_sc, w_sa, w_sb, w_sc;
  logic r_memreq, r_busy, r_halted, r_illegal;
  logic [15:0] r_retired;
  logic [1:0] w_op;
  logic w_illegal_op, w_retire, w_unused_ir;
  assign w_op = bus.uCONTROL_ir_InBUS[31:30];
  assign w_illegal_op = r_state == DECODE && w_op == 2'b01;
  assign w_retire = w_next == EXEC || w_next == BRANCH || w_illegal_op;
  assign w_unused_ir = ^{bus.uCONTROL_ir_InBUS[29], bus.uCONTROL_ir_InBUS[24:23], bus.uCONTROL_ir_InBUS[18:0]};
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   w_next = bus.uCONTROL_start_InHigh ? FETCH : IDLE;
      FETCH:  w_next = bus.uCONTROL_memack_InHigh ? PCINC : FETCH;
      PCINC:  w_next = DECODE;
      DECODE: w_next = w_op == 2'b10 ? EXEC : w_op == 2'b00 ? BRANCH : w_op == 2'b11 ? HALT : S_RETIRE;
      EXEC, BRANCH: w_next = S_RETIRE;
`ifdef SC_MICROSEQUENCER_SINGLE_STEP_EN
      PAUSE:  w_next = bus.uCONTROL_step_InHigh ? FETCH : PAUSE;
`endif
      default: w_next = r_state;
    endcase
  end
  // Outputs are decoded from the next state and registered, so they line up with the state they belong to.
  always_comb begin
    w_load = SEL_NONE;
    w_alu = ALU_SEL_PASSA;
    w_ca = '0;
    w_cc = '0;
    w_sa = 1'b0;
    w_sb = 1'b0;
    w_sc = 1'b0;
    w_clear = r_state == IDLE && w_next == FETCH ? REG_PC : SEL_NONE;
    case (w_next)
      PCINC: begin
        w_ca = CTL_PC;
        w_cc = CTL_PC;
        w_alu = ALU_SEL_INCA;
        w_load = REG_PC;
      end
      EXEC: begin
        w_sa = 1'b1;
        w_sb = 1'b1;
        w_sc = 1'b1;
        w_alu = bus.uCONTROL_ir_InBUS[22:19];
        w_load = bus.uCONTROL_ir_InBUS[28:25];
      end
      BRANCH: begin
        w_sa = !bus.uCONTROL_zero_InLow;
        w_cc = bus.uCONTROL_zero_InLow ? '0 : CTL_PC;
        w_load = bus.uCONTROL_zero_InLow ? SEL_NONE : REG_PC;
      end
      default: w_load = SEL_NONE;
    endcase
  end
  always_ff @(posedge uCONTROL_CLOCK_50 or posedge uCONTROL_RESET_InHigh) begin
    if (uCONTROL_RESET_InHigh) begin
      r_state <= IDLE;
      r_load <= SEL_NONE;
      r_clear <= SEL_NONE;
      r_alu <= ALU_SEL_PASSA;
      r_ca <= '0;
      r_cc <= '0;
      {r_sa, r_sb, r_sc} <= '0;
      {r_memreq, r_busy, r_halted, r_illegal} <= '0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      r_load <= w_load;
      r_clear <= w_clear;
      r_alu <= w_alu;
      r_ca <= w_ca;
      r_cc <= w_cc;
      {r_sa, r_sb, r_sc} <= {w_sa, w_sb, w_sc};
      r_memreq <= w_next == FETCH;
      r_busy <= w_next != IDLE && w_next != HALT;
      r_halted <= w_next == HALT;
      r_illegal <= r_illegal || w_illegal_op;
      r_retired <= r_retired + {15'd0, w_retire};
    end
  end
  // The IR load must land in the very cycle memory acknowledges, so it bypasses the output register.
  assign bus.uCONTROL_loadselection_OutBUS = r_state == FETCH && bus.uCONTROL_memack_InHigh ? REG_IR : r_load;
  assign bus.uCONTROL_clearselection_OutBUS = r_clear;
  assign bus.uCONTROL_aluselection_OutBUS = r_alu;
  assign bus.uCONTROL_BUS_CONTROL_A = r_ca;
  assign bus.uCONTROL_BUS_CONTROL_B = '0;
  assign bus.uCONTROL_BUS_CONTROL_C = r_cc;
  assign bus.uCONTROL_BUS_SELECTOR_A = r_sa;
  assign bus.uCONTROL_BUS_SELECTOR_B = r_sb;
  assign bus.uCONTROL_BUS_SELECTOR_C = r_sc;
  assign bus.uCONTROL_memreq_OutHigh = r_memreq;
  assign bus.uCONTROL_busy_OutHigh = r_busy;
  assign bus.uCONTROL_halted_OutHigh = r_halted;
  assign bus.uCONTROL_illegal_OutHigh = r_illegal;
  assign bus.uCONTROL_retired_OutBUS = r_retired;
endmodule

// File: tb/tb_sc_microsequencer.sv
// tb_sc_microsequencer: directed scoreboard bench for sc_microsequencer.
// Define SC_MICROSEQUENCER_SINGLE_STEP_EN to also cover the PAUSE/step behaviour.
module tb_sc_microsequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int compared = 0;
  int mismatched = 0;
  typedef struct {string tag; logic [31:0] v;} exp_t;
  exp_t sb[$];
  localparam logic [3:0] NONE = 4'hF;
  localparam logic [31:0] I_ALU = {2'b10, 5'd1, 2'b00, 4'b0010, 5'd2, 9'd0, 5'd3};
  localparam logic [31:0] I_BR = {2'b00, 5'd0, 2'b00, 4'd0, 5'd7, 9'd0, 5'd0};
  localparam logic [31:0] I_ILL = {2'b01, 30'd0};
  localparam logic [31:0] I_HALT = {2'b11, 30'd0};
  sc_microsequencer_if bus();
  sc_microsequencer dut (.uCONTROL_CLOCK_50(clk), .uCONTROL_RESET_InHigh(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic exp(input string t, input logic [31:0] v);
    sb.push_back('{tag: t, v: v});
  endtask
  task automatic chk(input logic [31:0] o);
    exp_t e;
    compared++;
    if (sb.size() == 0) begin
      mismatched++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", o);
    end else begin
      e = sb.pop_front();
      assert (o === e.v) else begin
        mismatched++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, o, e.v);
      end
    end
  endtask
  task automatic one(input string t, input logic [31:0] o, input logic [31:0] e);
    exp(t, e);
    chk(o);
  endtask
  task automatic push4(input string t, input logic [3:0] l, input logic [3:0] a, input logic m, input logic b);
    exp({t, ".load"}, 32'(l));
    exp({t, ".alu"}, 32'(a));
    exp({t, ".memreq"}, 32'(m));
    exp({t, ".busy"}, 32'(b));
  endtask
  task automatic pop4();
    chk(32'(bus.uCONTROL_loadselection_OutBUS));
    chk(32'(bus.uCONTROL_aluselection_OutBUS));
    chk(32'(bus.uCONTROL_memreq_OutHigh));
    chk(32'(bus.uCONTROL_busy_OutHigh));
  endtask
  task automatic look(input string t, input logic [3:0] l, input logic [3:0] a, input logic m, input logic b);
    push4(t, l, a, m, b);
    pop4();
  endtask
  task automatic tlook(input string t, input logic [3:0] l, input logic [3:0] a, input logic m, input logic b);
    push4(t, l, a, m, b);
    @(negedge clk);
    pop4();
  endtask
  task automatic resume();
`ifdef SC_MICROSEQUENCER_SINGLE_STEP_EN
    tlook("pause", NONE, 4'd0, 1'b0, 1'b1);
    bus.uCONTROL_step_InHigh = 1'b1;
    @(posedge clk);
    #1 bus.uCONTROL_step_InHigh = 1'b0;
`endif
  endtask
  initial begin
`ifdef SC_MICROSEQUENCER_SINGLE_STEP_EN
    bus.uCONTROL_step_InHigh = 1'b0;
`endif
    bus.uCONTROL_start_InHigh = 1'b0;
    bus.uCONTROL_memack_InHigh = 1'b0;
    bus.uCONTROL_ir_InBUS = I_ALU;
    bus.uCONTROL_zero_InLow = 1'b1;
    @(negedge clk);
    look("reset", NONE, 4'd0, 1'b0, 1'b0);
    one("reset.clear", 32'(bus.uCONTROL_clearselection_OutBUS), 32'(NONE));
    one("reset.retired", 32'(bus.uCONTROL_retired_OutBUS), 32'd0);
    one("reset.illegal", 32'(bus.uCONTROL_illegal_OutHigh), 32'd0);
    one("reset.halted", 32'(bus.uCONTROL_halted_OutHigh), 32'd0);
    rst = 1'b0;
    tlook("idle", NONE, 4'd0, 1'b0, 1'b0);
    bus.uCONTROL_start_InHigh = 1'b1;
    bus.uCONTROL_memack_InHigh = 1'b1;
    tlook("fetch", 4'd6, 4'd0, 1'b1, 1'b1);
    one("fetch.clear", 32'(bus.uCONTROL_clearselection_OutBUS), 32'd5);
    bus.uCONTROL_start_InHigh = 1'b0;
    tlook("pcinc", 4'd5, 4'd1, 1'b0, 1'b1);
    one("pcinc.ctlA", 32'(bus.uCONTROL_BUS_CONTROL_A), 32'd5);
    one("pcinc.ctlC", 32'(bus.uCONTROL_BUS_CONTROL_C), 32'd5);
    one("pcinc.selA", 32'(bus.uCONTROL_BUS_SELECTOR_A), 32'd0);
    one("pcinc.clear", 32'(bus.uCONTROL_clearselection_OutBUS), 32'(NONE));
    tlook("decode", NONE, 4'd0, 1'b0, 1'b1);
    tlook("exec", 4'd1, 4'b0010, 1'b0, 1'b1);
    one("exec.sel", 32'({bus.uCONTROL_BUS_SELECTOR_A, bus.uCONTROL_BUS_SELECTOR_B, bus.uCONTROL_BUS_SELECTOR_C}), 32'b111);
    one("exec.retired", 32'(bus.uCONTROL_retired_OutBUS), 32'd1);
    bus.uCONTROL_memack_InHigh = 1'b0;
    bus.uCONTROL_ir_InBUS = I_BR;
    bus.uCONTROL_zero_InLow = 1'b0;
    resume();
    for (int i = 0; i < 5; i++) tlook("fetch.wait", NONE, 4'd0, 1'b1, 1'b1);
    one("fetch.wait.clear", 32'(bus.uCONTROL_clearselection_OutBUS), 32'(NONE));
    @(negedge clk);
    bus.uCONTROL_memack_InHigh = 1'b1;
    #1 look("fetch.ack", 4'd6, 4'd0, 1'b1, 1'b1);
    tlook("pcinc2", 4'd5, 4'd1, 1'b0, 1'b1);
    tlook("decode2", NONE, 4'd0, 1'b0, 1'b1);
    tlook("branch.taken", 4'd5, 4'd0, 1'b0, 1'b1);
    one("branch.taken.selA", 32'(bus.uCONTROL_BUS_SELECTOR_A), 32'd1);
    one("branch.taken.retired", 32'(bus.uCONTROL_retired_OutBUS), 32'd2);
    bus.uCONTROL_zero_InLow = 1'b1;
    resume();
    tlook("fetch3", 4'd6, 4'd0, 1'b1, 1'b1);
    tlook("pcinc3", 4'd5, 4'd1, 1'b0, 1'b1);
    tlook("decode3", NONE, 4'd0, 1'b0, 1'b1);
    tlook("branch.nt", NONE, 4'd0, 1'b0, 1'b1);
    one("branch.nt.retired", 32'(bus.uCONTROL_retired_OutBUS), 32'd3);
    bus.uCONTROL_ir_InBUS = I_ILL;
    resume();
    tlook("fetch4", 4'd6, 4'd0, 1'b1, 1'b1);
    tlook("pcinc4", 4'd5, 4'd1, 1'b0, 1'b1);
    tlook("decode.ill", NONE, 4'd0, 1'b0, 1'b1);
    one("decode.ill.flag", 32'(bus.uCONTROL_illegal_OutHigh), 32'd0);
    resume();
    tlook("fetch.after_ill", 4'd6, 4'd0, 1'b1, 1'b1);
    one("ill.flag", 32'(bus.uCONTROL_illegal_OutHigh), 32'd1);
    one("ill.retired", 32'(bus.uCONTROL_retired_OutBUS), 32'd4);
    bus.uCONTROL_ir_InBUS = I_ALU;
    tlook("pcinc5", 4'd5, 4'd1, 1'b0, 1'b1);
    tlook("decode5", NONE, 4'd0, 1'b0, 1'b1);
    tlook("exec5", 4'd1, 4'b0010, 1'b0, 1'b1);
    one("ill.sticky", 32'(bus.uCONTROL_illegal_OutHigh), 32'd1);
    one("exec5.retired", 32'(bus.uCONTROL_retired_OutBUS), 32'd5);
    rst = 1'b1;
    #1 look("async_rst", NONE, 4'd0, 1'b0, 1'b0);
    one("async_rst.illegal", 32'(bus.uCONTROL_illegal_OutHigh), 32'd0);
    one("async_rst.retired", 32'(bus.uCONTROL_retired_OutBUS), 32'd0);
    one("async_rst.sel", 32'({bus.uCONTROL_BUS_SELECTOR_A, bus.uCONTROL_BUS_SELECTOR_B, bus.uCONTROL_BUS_SELECTOR_C}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.uCONTROL_ir_InBUS = I_HALT;
    tlook("post_rst.idle", NONE, 4'd0, 1'b0, 1'b0);
    bus.uCONTROL_start_InHigh = 1'b1;
    tlook("fetch6", 4'd6, 4'd0, 1'b1, 1'b1);
    bus.uCONTROL_start_InHigh = 1'b0;
    tlook("pcinc6", 4'd5, 4'd1, 1'b0, 1'b1);
    tlook("decode6", NONE, 4'd0, 1'b0, 1'b1);
    tlook("halt", NONE, 4'd0, 1'b0, 1'b0);
    one("halt.halted", 32'(bus.uCONTROL_halted_OutHigh), 32'd1);
    bus.uCONTROL_start_InHigh = 1'b1;
    tlook("halt.start", NONE, 4'd0, 1'b0, 1'b0);
    tlook("halt.start2", NONE, 4'd0, 1'b0, 1'b0);
    one("halt.stays", 32'(bus.uCONTROL_halted_OutHigh), 32'd1);
    bus.uCONTROL_start_InHigh = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    force dut.r_retired = 16'hFFFF;
    @(negedge clk);
    release dut.r_retired;
    bus.uCONTROL_ir_InBUS = I_ALU;
    bus.uCONTROL_start_InHigh = 1'b1;
    tlook("fetch7", 4'd6, 4'd0, 1'b1, 1'b1);
    bus.uCONTROL_start_InHigh = 1'b0;
    tlook("pcinc7", 4'd5, 4'd1, 1'b0, 1'b1);
    tlook("decode7", NONE, 4'd0, 1'b0, 1'b1);
    one("pre_wrap.retired", 32'(bus.uCONTROL_retired_OutBUS), 32'hFFFF);
    tlook("exec7", 4'd1, 4'b0010, 1'b0, 1'b1);
    one("wrap.retired", 32'(bus.uCONTROL_retired_OutBUS), 32'd0);
`ifdef SC_MICROSEQUENCER_SINGLE_STEP_EN
    for (int i = 0; i < 10; i++) tlook("pause.hold", NONE, 4'd0, 1'b0, 1'b1);
    begin
      int fetches;
      fetches = 0;
      bus.uCONTROL_step_InHigh = 1'b1;
      @(posedge clk);
      #1 bus.uCONTROL_step_InHigh = 1'b0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        fetches += int'(bus.uCONTROL_memreq_OutHigh);
      end
      one("step.fetches", 32'(fetches), 32'd1);
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
